csc_pixel_serializer: RTL and testbench

- Downstream stage of the colour space conversion block.
- Delays a pixel-valid/start-of-frame qualifier to line up with the converter's registered 3-component output, buffers converted pixels in a small FIFO, and serialises each pixel into three 8-bit bytes on a valid/ready byte stream (UART/DMA side).
- Gives upstream an almost-full throttle, since the converter itself cannot stall.

---
 rtl/csc_pkg.sv | 29 ++
 rtl/csc_sync_fifo.sv | 59 +++++
 rtl/csc_pixel_serializer.sv | 161 ++++++++++++++++
 tb/tb_csc_pixel_serializer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/csc_pkg.sv
// rtl/csc_pkg.sv - shared types and constants for the colour space conversion datapath
package csc_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int PIX_W      = 3 * DATA_WIDTH + 1;

    typedef enum logic [1:0] {
        RGB = 2'b00,
        YUV = 2'b01,
        CMY = 2'b10,
        HSV = 2'b11
    } csc_space_e;

    // Field order fixes the FIFO word layout: {sof, comp1, comp2, comp3}
    typedef struct packed {
        logic                  sof;
        logic [DATA_WIDTH-1:0] c1;
        logic [DATA_WIDTH-1:0] c2;
        logic [DATA_WIDTH-1:0] c3;
    } pixel_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        C1   = 2'b01,
        C2   = 2'b10,
        C3   = 2'b11
    } ser_state_e;

endpackage

// File: rtl/csc_sync_fifo.sv
// rtl/csc_sync_fifo.sv - single-clock FIFO with occupancy count, push-on-full allowed with a same-cycle pop
module csc_sync_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic [WIDTH-1:0]               din,
    input  logic                           pop,
    output logic [WIDTH-1:0]               dout,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage is left unreset; only pointers and count define validity
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/csc_pixel_serializer.sv
// rtl/csc_pixel_serializer.sv - aligns converter output with its qualifiers, buffers pixels and emits them as 3-byte bursts
module csc_pixel_serializer #(
    parameter int CSC_LATENCY  = 1,
    parameter int FIFO_DEPTH   = 8,
    parameter int AFULL_MARGIN = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_valid_in,
    input  logic       pix_sof_in,
    input  logic [7:0] data_in1,
    input  logic [7:0] data_in2,
    input  logic [7:0] data_in3,
    output logic       fifo_afull,
    output logic       overflow,
    input  logic       ovf_clear,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_sof,
    output logic       m_last
);

    import csc_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [CSC_LATENCY-1:0] valid_pipe;
    logic [CSC_LATENCY-1:0] sof_pipe;
    logic                   wr_en;
    logic                   sof_d;
    pixel_t                 wr_pix;
    pixel_t                 rd_pix;
    logic [PIX_W-1:0]       fifo_dout;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CW-1:0]          fifo_count;
    logic [CW-1:0]          count_nxt;
    logic                   accept;
    logic                   drop;
    logic                   pop;
    ser_state_e             state_q;
    ser_state_e             state_d;
    logic [3*DATA_WIDTH-1:0] hold_q;
    logic                   hold_sof_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_pipe <= '0;
            sof_pipe   <= '0;
        end else begin
            valid_pipe[0] <= pix_valid_in;
            sof_pipe[0]   <= pix_valid_in && pix_sof_in;
            for (int i = 1; i < CSC_LATENCY; i++) begin
                valid_pipe[i] <= valid_pipe[i-1];
                sof_pipe[i]   <= sof_pipe[i-1];
            end
        end
    end

    assign wr_en  = valid_pipe[CSC_LATENCY-1];
    assign sof_d  = sof_pipe[CSC_LATENCY-1];
    assign wr_pix = {sof_d, data_in1, data_in2, data_in3};
    assign rd_pix = fifo_dout;

    // A full FIFO still takes the pixel when the serializer frees a slot this cycle
    assign accept    = wr_en && (!fifo_full || pop);
    assign drop      = wr_en && !accept;
    assign count_nxt = fifo_count + CW'(accept) - CW'(pop);

    csc_sync_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_en),
        .din   (wr_pix),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_afull <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            fifo_afull <= (count_nxt >= CW'(FIFO_DEPTH - AFULL_MARGIN));
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            hold_sof_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                hold_q     <= {rd_pix.c1, rd_pix.c2, rd_pix.c3};
                hold_sof_q <= rd_pix.sof;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        m_sof   = 1'b0;
        m_last  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = C1;
                end
            end
            C1: begin
                m_valid = 1'b1;
                m_data  = hold_q[23:16];
                m_sof   = hold_sof_q;
                if (m_ready) begin
                    state_d = C2;
                end
            end
            C2: begin
                m_valid = 1'b1;
                m_data  = hold_q[15:8];
                if (m_ready) begin
                    state_d = C3;
                end
            end
            C3: begin
                m_valid = 1'b1;
                m_data  = hold_q[7:0];
                m_last  = 1'b1;
                // Reload straight from C3 so consecutive pixels leave no gap
                if (m_ready) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = C1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_csc_pixel_serializer.sv
// tb/tb_csc_pixel_serializer.sv - directed self-checking bench for csc_pixel_serializer
module tb_csc_pixel_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pix_valid_in = 1'b0;
    logic       pix_sof_in = 1'b0;
    logic [7:0] data_in1 = 8'h00;
    logic [7:0] data_in2 = 8'h00;
    logic [7:0] data_in3 = 8'h00;
    logic       fifo_afull;
    logic       overflow;
    logic       ovf_clear = 1'b0;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic       m_sof;
    logic       m_last;

    always #5 clk = ~clk;

    csc_pixel_serializer #(
        .CSC_LATENCY  (1),
        .FIFO_DEPTH   (8),
        .AFULL_MARGIN (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pix_valid_in (pix_valid_in),
        .pix_sof_in   (pix_sof_in),
        .data_in1     (data_in1),
        .data_in2     (data_in2),
        .data_in3     (data_in3),
        .fifo_afull   (fifo_afull),
        .overflow     (overflow),
        .ovf_clear    (ovf_clear),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_sof        (m_sof),
        .m_last       (m_last)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         afull_hits = 0;
    int         rx_base = 0;
    logic [9:0] rx_q[$];
    int         rx_cyc[$];
    logic [9:0] exp_q[$];
    logic       prev_v = 1'b0;
    logic       prev_r = 1'b0;
    logic [9:0] prev_bits = '0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Byte collector plus hold-stable check while a byte is stalled
    always @(negedge clk) begin
        if (!reset) begin
            if (prev_v && !prev_r) begin
                chk("stall_valid", 32'(m_valid), 32'd1);
                chk("stall_stable", 32'({m_sof, m_last, m_data}), 32'(prev_bits));
            end
            if (m_valid && m_ready) begin
                rx_q.push_back({m_sof, m_last, m_data});
                rx_cyc.push_back(cyc);
            end
            if (fifo_afull) afull_hits <= afull_hits + 1;
        end
        prev_v    <= m_valid && !reset;
        prev_r    <= m_ready;
        prev_bits <= {m_sof, m_last, m_data};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(logic sof, logic [7:0] c1, logic [7:0] c2, logic [7:0] c3);
        exp_q.push_back({sof, 1'b0, c1});
        exp_q.push_back({2'b00, c2});
        exp_q.push_back({2'b01, c3});
    endtask

    task automatic drive_pixel(logic sof, logic [7:0] c1, logic [7:0] c2, logic [7:0] c3);
        pix_valid_in = 1'b1;
        pix_sof_in   = sof;
        data_in1 = c1; data_in2 = c2; data_in3 = c3;
        tick();
        pix_valid_in = 1'b0;
        pix_sof_in   = 1'b0;
        tick();
        tick();
    endtask

    task automatic wait_bytes(int n, int budget, string tag);
        int k = 0;
        while ((rx_q.size() - rx_base) < n && k < budget) begin
            tick();
            k++;
        end
        chk({tag, "_wait"}, 32'(rx_q.size() - rx_base), 32'(n));
    endtask

    task automatic compare_rx(string tag);
        int n = exp_q.size();
        chk({tag, "_nbytes"}, 32'(rx_q.size() - rx_base), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (rx_base + i < rx_q.size())
                chk($sformatf("%s_b%0d", tag, i), 32'(rx_q[rx_base + i]), 32'(exp_q[i]));
        end
        rx_base = rx_q.size();
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int hits0;

        // Reset state
        repeat (3) tick();
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_sof_last", 32'({m_sof, m_last}), 32'd0);
        chk("rst_afull", 32'(fifo_afull), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        repeat (2) tick();

        // Single pixel latency: first byte CSC_LATENCY+2 cycles after the input
        m_ready = 1'b1;
        t0 = cyc;
        push_exp(1'b1, 8'h12, 8'h34, 8'h56);
        drive_pixel(1'b1, 8'h12, 8'h34, 8'h56);
        wait_bytes(3, 20, "single");
        chk("single_idle_after", 32'(m_valid), 32'd0);
        for (int i = 0; i < 3; i++)
            if (rx_base + i < rx_cyc.size())
                chk($sformatf("single_cyc%0d", i), 32'(rx_cyc[rx_base + i]), 32'(t0 + 3 + i));
        compare_rx("single");
        repeat (3) tick();

        // Back-to-back at one pixel every 3 cycles: contiguous bytes, no throttle
        hits0 = afull_hits;
        for (int k = 0; k < 4; k++) begin
            push_exp(k == 0, 8'(8'h20 + 3*k), 8'(8'h21 + 3*k), 8'(8'h22 + 3*k));
            drive_pixel(k == 0, 8'(8'h20 + 3*k), 8'(8'h21 + 3*k), 8'(8'h22 + 3*k));
        end
        wait_bytes(12, 40, "b2b");
        for (int i = 1; i < 12; i++)
            if (rx_base + i < rx_cyc.size())
                chk($sformatf("b2b_contig%0d", i), 32'(rx_cyc[rx_base + i] - rx_cyc[rx_base]), 32'(i));
        chk("b2b_no_afull", 32'(afull_hits - hits0), 32'd0);
        compare_rx("b2b");
        repeat (3) tick();

        // Backpressure: one pixel sits in the hold register, the rest fill the FIFO
        m_ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            push_exp(k == 0, 8'(8'h40 + 3*k), 8'(8'h41 + 3*k), 8'(8'h42 + 3*k));
            drive_pixel(k == 0, 8'(8'h40 + 3*k), 8'(8'h41 + 3*k), 8'(8'h42 + 3*k));
            if (k == 5) chk("bp_afull_occ5", 32'(fifo_afull), 32'd0);
        end
        chk("bp_afull_occ6", 32'(fifo_afull), 32'd1);
        chk("bp_head_held", 32'({m_valid, m_sof, m_last, m_data}), 32'({3'b110, 8'h40}));
        m_ready = 1'b1;
        wait_bytes(21, 100, "bp");
        compare_rx("bp");
        chk("bp_afull_drained", 32'(fifo_afull), 32'd0);
        repeat (3) tick();

        // Overflow: hold register + 8 FIFO entries, the 10th pixel is dropped
        m_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            push_exp(k == 0, 8'(8'h60 + 3*k), 8'(8'h61 + 3*k), 8'(8'h62 + 3*k));
            drive_pixel(k == 0, 8'(8'h60 + 3*k), 8'(8'h61 + 3*k), 8'(8'h62 + 3*k));
        end
        chk("ovf_full_no_drop", 32'(overflow), 32'd0);
        chk("ovf_count_full", 32'(dut.fifo_count), 32'd8);
        drive_pixel(1'b0, 8'hE0, 8'hE1, 8'hE2);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count_unchanged", 32'(dut.fifo_count), 32'd8);
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);
        // Drop and clear in the same cycle: set wins
        pix_valid_in = 1'b1;
        data_in1 = 8'hE3; data_in2 = 8'hE4; data_in3 = 8'hE5;
        tick();
        pix_valid_in = 1'b0;
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        chk("ovf_set_priority", 32'(overflow), 32'd1);
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        chk("ovf_cleared2", 32'(overflow), 32'd0);

        // Full FIFO: push lands in the same cycle as the C3->C1 pop
        m_ready = 1'b1;
        tick();
        pix_valid_in = 1'b1;
        data_in1 = 8'hC0; data_in2 = 8'hC1; data_in3 = 8'hC2;
        push_exp(1'b0, 8'hC0, 8'hC1, 8'hC2);
        tick();
        pix_valid_in = 1'b0;
        tick();
        m_ready = 1'b0;
        chk("fullpop_bytes", 32'(rx_q.size() - rx_base), 32'd3);
        chk("fullpop_count", 32'(dut.fifo_count), 32'd8);
        chk("fullpop_no_ovf", 32'(overflow), 32'd0);
        chk("fullpop_afull", 32'(fifo_afull), 32'd1);
        tick();
        m_ready = 1'b1;
        wait_bytes(30, 150, "ovf");
        compare_rx("ovf");
        repeat (3) tick();
        chk("ovf_drained_idle", 32'(m_valid), 32'd0);

        // Reset while component 3 of a pixel is on the bus, next pixel queued
        pix_valid_in = 1'b1; pix_sof_in = 1'b1;
        data_in1 = 8'h11; data_in2 = 8'h22; data_in3 = 8'h33;
        tick();
        pix_valid_in = 1'b0; pix_sof_in = 1'b0;
        tick();
        tick();
        pix_valid_in = 1'b1;
        data_in1 = 8'h44; data_in2 = 8'h55; data_in3 = 8'h66;
        tick();
        pix_valid_in = 1'b0;
        tick();
        chk("rstmid_two_bytes", 32'(rx_q.size() - rx_base), 32'd2);
        reset = 1'b1;
        #1;
        chk("rstmid_m_valid", 32'(m_valid), 32'd0);
        chk("rstmid_outputs", 32'({m_sof, m_last, m_data}), 32'd0);
        exp_q.push_back({2'b10, 8'h11});
        exp_q.push_back({2'b00, 8'h22});
        compare_rx("rstmid_pre");
        tick();
        tick();
        reset = 1'b0;
        repeat (8) tick();
        chk("rstmid_no_stale", 32'(rx_q.size() - rx_base), 32'd0);
        push_exp(1'b1, 8'h77, 8'h88, 8'h99);
        drive_pixel(1'b1, 8'h77, 8'h88, 8'h99);
        wait_bytes(3, 20, "rstmid_new");
        compare_rx("rstmid_new");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
